hazard_forward_unit: RTL
========================

// Module: hazard_forward_unit
// PURPOSE
//  Producer of the 2-bit forwarding selects consumed by the Execute-stage three-input operand muxes
//  (00 = register-file operand, 01 = WB result, 10 = MEM ALU result).
//  Tracks rd/reg_write/mem_read of in-flight instructions in internal shadow registers (EX, MEM, WB).
//  Generates load-use stalls, branch flushes and whole-pipe freeze on data-memory wait.
// PARAMETERS
//  REG_AW   5   register-address width
//  CNT_W    32  perf-counter width (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       synchronous reset, active-low
//  id_valid       in   1       instruction present in ID
//  id_rs1/id_rs2  in   REG_AW  source registers of ID instruction
//  id_rs1_used    in   1       ID instruction reads rs1 (same for id_rs2_used)
//  id_rs2_used    in   1
//  id_rd          in   REG_AW  destination of ID instruction
//  id_reg_write   in   1       ID instruction writes rd
//  id_mem_read    in   1       ID instruction is a load
//  ex_pc_src      in   1       branch/jump taken, resolved in EX
//  mem_wait       in   1       data memory not ready; freeze pipeline
//  forward_a_sel  out  2       EX operand-A select
//  forward_b_sel  out  2       EX operand-B select
//  stall_f/stall_d out 1       hold PC / IF-ID register
//  stall_e/stall_m out 1       hold ID-EX / EX-MEM (asserted only in FREEZE)
//  flush_d/flush_e out 1       clear IF-ID / ID-EX register
//  stall_count    out  CNT_W   cycles with stall_f=1
//  flush_count    out  CNT_W   taken-branch flushes
// BEHAVIOUR
//  - Shadow entries {valid, rs1, rs2, rd, reg_write, mem_read} for EX; {valid, rd, reg_write} for MEM and WB.
//    Advance EX->MEM->WB each cycle unless in FREEZE.
//  - EX entry loads the ID fields when no stall/flush; loads a bubble (valid=0) when flush_e=1.
//  - Forwarding (combinational from EX shadow):
//    sel=10 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rsN;
//    else 01 for the same test against WB;
//    else 00. MEM wins over WB. x0 is never forwarded.
//  - Load-use: id_valid & EX.valid & EX.mem_read & EX.rd!=0 & (rs1 match & rs1_used | rs2 match & rs2_used)
//    -> stall_f=stall_d=flush_e=1 for exactly one cycle. The load reaches WB when the consumer enters EX (sel=01).
//  - Branch: ex_pc_src=1 -> flush_d=flush_e=1 the same cycle.
//    Flush overrides load-use: stall_f=stall_d=0, no LDSTALL entry.
//  - FSM (registered):
//    RUN -> LDSTALL on load-use hazard; LDSTALL -> RUN unconditionally.
//    Any state -> FREEZE when mem_wait=1; FREEZE -> RUN when mem_wait=0.
//    FREEZE: all four stalls=1, flushes=0, shadow registers hold, forward selects hold their current value.
//    mem_wait has priority over load-use and branch. The branch is re-evaluated after the freeze because the EX shadow holds.
//  - Reset: on any clk edge with rst_n=0, state=RUN, all shadow valid=0, counters=0, regardless of state.
//    After that edge, outputs are selects=00 and stalls/flushes=0.
//  - Latency: selects, stalls and flushes are combinational from current shadow state and ID inputs (0 cycles).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    stall_count +1 each cycle stall_f=1; flush_count +1 each cycle ex_pc_src=1 outside FREEZE.
//    Both wrap modulo 2^CNT_W.
//  Undefined: no counter flops; stall_count and flush_count are tied to 0.
// STRUCTURE
//  hazard_pkg:
//    FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
//    state enum RUN/LDSTALL/FREEZE;
//    shadow-entry field widths.
//  Sub-module hazard_fwd_cmp: one per operand; inputs rs, MEM/WB entries; output 2-bit select.
// TESTING
//  1. add x5 in MEM, sub using x5 in EX -> forward_a_sel=10; same x5 also in WB -> still 10.
//  2. lw x6 in EX, ID add uses x6 via rs2 -> one cycle stall_f=stall_d=flush_e=1.
//     Next cycle forward_b_sel=01 when the add is in EX.
//  3. Instruction writes x0 in MEM, consumer reads x0 -> forward_a_sel=00.
//  4. ex_pc_src=1 coincident with load-use -> flush_d=flush_e=1, stall_f=0; FSM stays RUN.
//  5. mem_wait=1 for 3 cycles mid-stream -> all stalls=1 for 3 cycles, selects unchanged.
//     Resume with identical forwarding.
//  6. rst_n=0 during LDSTALL, then release -> selects=00, stalls/flushes=0; counters=0 (with HAZARD_PERF_CNT_EN).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: forward selects, FSM states, shadow widths.
// Pure definitions; no logic.
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } hz_state_t;

  // Default register-address width and the payload widths of the shadow entries built from it.
  localparam int SHADOW_REG_AW   = 5;
  localparam int EX_ENTRY_W      = 1 + 3 * SHADOW_REG_AW + 2;
  localparam int MEMWB_ENTRY_W   = 1 + SHADOW_REG_AW + 1;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Forward-select compare for one EX operand against the MEM and WB shadow entries.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// The younger MEM result wins over WB; x0 is never forwarded.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = SHADOW_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REGFILE;
    if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard unit: EX forward selects, load-use stall, branch flush, pipeline freeze; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: selects/stalls/flushes combinational from shadow state and ID inputs; shadows and FSM registered.
// Backpressure: mem_wait freezes every stage; a load-use hazard holds IF/ID for one cycle.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = SHADOW_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_pc_src,
  input  logic              mem_wait,
  output logic [1:0]        forward_a_sel,
  output logic [1:0]        forward_b_sel,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  hz_state_t state;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;

  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;

  logic ld_hit;
  logic load_use;

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (forward_a_sel)
  );

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (forward_b_sel)
  );

  // The LDSTALL gate guarantees the stall never stretches past one cycle.
  always_comb begin
    ld_hit = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
             ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    load_use = ld_hit && (state != LDSTALL);
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else begin
      flush_d = ex_pc_src;
      flush_e = ex_pc_src || load_use;
      stall_f = load_use && !ex_pc_src;
      stall_d = load_use && !ex_pc_src;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      ex_valid      <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      if (mem_wait) begin
        state <= FREEZE;
      end else begin
        case (state)
          RUN:     state <= (load_use && !ex_pc_src) ? LDSTALL : RUN;
          LDSTALL: state <= RUN;
          FREEZE:  state <= RUN;
          default: state <= RUN;
        endcase
      end

      // Shadows hold during a freeze so a pending branch is re-evaluated afterwards.
      if (!mem_wait) begin
        wb_valid      <= mem_valid;
        wb_rd         <= mem_rd;
        wb_reg_write  <= mem_reg_write;
        mem_valid     <= ex_valid;
        mem_rd        <= ex_rd;
        mem_reg_write <= ex_reg_write;
        if (flush_e) begin
          ex_valid     <= 1'b0;
          ex_rs1       <= '0;
          ex_rs2       <= '0;
          ex_rd        <= '0;
          ex_reg_write <= 1'b0;
          ex_mem_read  <= 1'b0;
        end else begin
          ex_valid     <= id_valid;
          ex_rs1       <= id_rs1;
          ex_rs2       <= id_rs2;
          ex_rd        <= id_rd;
          ex_reg_write <= id_reg_write;
          ex_mem_read  <= id_mem_read;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (ex_pc_src && !mem_wait) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
